bit_packer: RTL and testbench



---
 rtl/bit_pack_pkg.sv | 44 ++++
 rtl/bit_packer_if.sv | 39 +++
 rtl/bit_pack_acc.sv | 95 +++++++++
 rtl/bit_packer.sv | 128 ++++++++++++
 tb/tb_bit_packer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bit_pack_pkg.sv
`default_nettype none
// ============================================================
// Module  : bit_pack_pkg
// Brief   : FSM type and width helpers shared by the bit packer.
// Revision: 1.0 - initial release
// ============================================================
package bit_pack_pkg;

   localparam int DEF_N     = 256;
   localparam int DEF_MAX_W = 13;
   localparam int DEF_OUT_W = 64;
   localparam int WIDTH_W   = 4;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_DRAIN = 3'd2,
      S_FLUSH = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   function automatic int clog2_min1(input int v);
      return (v > 1) ? $clog2(v) : 1;
   endfunction

   // Worst case holds OUT_W-1 leftover bits plus one MAX_W coefficient.
   function automatic int acc_width(input int out_w, input int max_w);
      return out_w + max_w - 1;
   endfunction

   function automatic int fill_width(input int out_w, input int max_w);
      return $clog2(out_w + max_w);
   endfunction

   function automatic int oaddr_width(input int n, input int max_w, input int out_w);
      return clog2_min1((n * max_w + out_w - 1) / out_w);
   endfunction

   function automatic logic width_legal(input logic [WIDTH_W-1:0] w, input int max_w);
      return (w != '0) && (int'(w) <= max_w);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bit_packer_if.sv
`default_nettype none
// ============================================================
// Module  : bit_packer_if
// Brief   : Job control, coefficient RAM read and packed-word write bus.
// Revision: 1.0 - initial release
// ============================================================
interface bit_packer_if
   import bit_pack_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int MAX_W = DEF_MAX_W,
   parameter int OUT_W = DEF_OUT_W
);
   localparam int ADDR_W  = clog2_min1(N);
   localparam int OADDR_W = oaddr_width(N, MAX_W, OUT_W);

   logic                start;
   logic [WIDTH_W-1:0]  width;
   logic [MAX_W-1:0]    in;
   logic                in_en;
   logic [ADDR_W-1:0]   in_addr;
   logic [OUT_W-1:0]    out;
   logic                out_en;
   logic [OADDR_W-1:0]  out_addr;
   logic                busy;
   logic                done;
   logic                err;

   modport master (
      input  start, width, in,
      output in_en, in_addr, out, out_en, out_addr, busy, done, err
   );

   modport slave (
      output start, width, in,
      input  in_en, in_addr, out, out_en, out_addr, busy, done, err
   );
endinterface
`default_nettype wire

// File: rtl/bit_pack_acc.sv
`default_nettype none
// ============================================================
// Module  : bit_pack_acc
// Brief   : Bit accumulator: masks, appends and emits OUT_W-bit words.
// Revision: 1.0 - initial release
// ============================================================
module bit_pack_acc
   import bit_pack_pkg::*;
#(
   parameter int MAX_W = DEF_MAX_W,
   parameter int OUT_W = DEF_OUT_W
) (
   input  wire logic               clk,
   input  wire logic               rst,
   input  wire logic               i_clr,
   input  wire logic               i_vld,
   input  wire logic               i_flush,
   input  wire logic [WIDTH_W-1:0] i_w,
   input  wire logic [MAX_W-1:0]   i_data,
   output logic [OUT_W-1:0]        o_word,
   output logic                    o_word_en,
   output logic                    o_pending
);
   localparam int ACC_W  = acc_width(OUT_W, MAX_W);
   localparam int FILL_W = fill_width(OUT_W, MAX_W);
   localparam logic [FILL_W-1:0] FILL_OUT = FILL_W'(OUT_W);

   logic [ACC_W-1:0]  r_acc;
   logic [ACC_W-1:0]  w_acc_sum;
   logic [ACC_W-1:0]  w_acc_nxt;
   logic [FILL_W-1:0] r_fill;
   logic [FILL_W-1:0] w_fill_sum;
   logic [FILL_W-1:0] w_fill_nxt;
   logic [MAX_W-1:0]  w_mask;
   logic              w_emit;
   logic [OUT_W-1:0]  r_word;
   logic              r_word_en;

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < MAX_W; i++) begin
         w_mask[i] = (i < int'(i_w));
      end
   end

   // Bits above the active width are stripped before they can reach the next field.
   assign w_acc_sum  = r_acc | (ACC_W'(i_data & w_mask) << r_fill);
   assign w_fill_sum = r_fill + FILL_W'(i_w);
   assign w_emit     = i_vld && (w_fill_sum >= FILL_OUT);

   always_comb begin
      w_acc_nxt  = r_acc;
      w_fill_nxt = r_fill;
      if (i_flush) begin
         w_acc_nxt  = '0;
         w_fill_nxt = '0;
      end else if (i_vld) begin
         if (w_emit) begin
            w_acc_nxt  = w_acc_sum >> OUT_W;
            w_fill_nxt = w_fill_sum - FILL_OUT;
         end else begin
            w_acc_nxt  = w_acc_sum;
            w_fill_nxt = w_fill_sum;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc     <= '0;
         r_fill    <= '0;
         r_word    <= '0;
         r_word_en <= 1'b0;
      end else if (i_clr) begin
         r_acc     <= '0;
         r_fill    <= '0;
         r_word_en <= 1'b0;
      end else begin
         r_acc     <= w_acc_nxt;
         r_fill    <= w_fill_nxt;
         r_word_en <= w_emit || i_flush;
         if (w_emit) begin
            r_word <= w_acc_sum[OUT_W-1:0];
         end else if (i_flush) begin
            r_word <= r_acc[OUT_W-1:0];
         end
      end
   end

   assign o_word    = r_word;
   assign o_word_en = r_word_en;
   assign o_pending = (w_fill_nxt != '0);

endmodule
`default_nettype wire

// File: rtl/bit_packer.sv
`default_nettype none
// ============================================================
// Module  : bit_packer
// Brief   : Runtime-width coefficient packer: job FSM, RAM addressing, word output.
// Revision: 1.0 - initial release
// ============================================================
module bit_packer
   import bit_pack_pkg::*;
#(
   parameter int N     = DEF_N,
   parameter int MAX_W = DEF_MAX_W,
   parameter int OUT_W = DEF_OUT_W
) (
   input  wire logic    clk,
   input  wire logic    reset,
   bit_packer_if.master bus
);
   localparam int ADDR_W  = clog2_min1(N);
   localparam int OADDR_W = oaddr_width(N, MAX_W, OUT_W);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_cnt;
   logic [WIDTH_W-1:0]  r_wq;
   logic                r_rd_vld;
   logic                r_err;
   logic [OADDR_W-1:0]  r_oaddr;
   logic                w_width_ok;
   logic                w_accept;
   logic                w_in_en;
   logic                w_flush;
   logic                w_busy;
   logic                w_done;
   logic [OUT_W-1:0]    w_word;
   logic                w_word_en;
   logic                w_pending;

   assign w_width_ok = width_legal(bus.width, MAX_W);
   assign w_accept   = (r_state == S_IDLE) && bus.start && w_width_ok;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // DRAIN looks at the post-pack fill so the last coefficient is counted.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_READ;
         S_READ:  if (r_cnt == LAST_ADDR) w_state_nxt = S_DRAIN;
         S_DRAIN: w_state_nxt = w_pending ? S_FLUSH : S_FIN;
         S_FLUSH: w_state_nxt = S_FIN;
         S_FIN:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_in_en = 1'b0;
      w_flush = 1'b0;
      w_busy  = 1'b1;
      w_done  = 1'b0;
      case (r_state)
         S_IDLE:  w_busy  = 1'b0;
         S_READ:  w_in_en = 1'b1;
         S_FLUSH: w_flush = 1'b1;
         S_FIN:   w_done  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt    <= '0;
         r_wq     <= '0;
         r_rd_vld <= 1'b0;
         r_err    <= 1'b0;
         r_oaddr  <= '0;
      end else begin
         r_rd_vld <= w_in_en;
         r_err    <= (r_state == S_IDLE) && bus.start && !w_width_ok;
         if (w_accept) begin
            r_cnt   <= '0;
            r_wq    <= bus.width;
            r_oaddr <= '0;
         end else begin
            if (w_in_en) begin
               r_cnt <= r_cnt + ADDR_W'(1);
            end
            if (w_word_en) begin
               r_oaddr <= r_oaddr + OADDR_W'(1);
            end
         end
      end
   end

   bit_pack_acc #(
      .MAX_W (MAX_W),
      .OUT_W (OUT_W)
   ) u_acc (
      .clk       (clk),
      .rst       (reset),
      .i_clr     (w_accept),
      .i_vld     (r_rd_vld),
      .i_flush   (w_flush),
      .i_w       (r_wq),
      .i_data    (bus.in),
      .o_word    (w_word),
      .o_word_en (w_word_en),
      .o_pending (w_pending)
   );

   assign bus.in_en    = w_in_en;
   assign bus.in_addr  = r_cnt;
   assign bus.out      = w_word;
   assign bus.out_en   = w_word_en;
   assign bus.out_addr = r_oaddr;
   assign bus.busy     = w_busy;
   assign bus.done     = w_done;
   assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bit_packer.sv
`default_nettype none
// ============================================================
// Module  : tb_bit_packer
// Brief   : Self-checking bench: bitstream reference model plus directed jobs.
// Revision: 1.0 - initial release
// ============================================================
module tb_bit_packer;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bit_packer_if #(.N(256), .MAX_W(13), .OUT_W(64)) ifa ();
   bit_packer_if #(.N(5),   .MAX_W(13), .OUT_W(64)) ifb ();

   bit_packer #(.N(256), .MAX_W(13), .OUT_W(64)) dut_a (.clk(clk), .reset(rst), .bus(ifa));
   bit_packer #(.N(5),   .MAX_W(13), .OUT_W(64)) dut_b (.clk(clk), .reset(rst), .bus(ifb));

   logic [12:0] coef [256];

   // Coefficient RAM with one cycle of read latency, shared by both instances.
   always @(posedge clk) begin
      if (ifa.in_en) ifa.in <= coef[int'(ifa.in_addr)];
      if (ifb.in_en) ifb.in <= coef[int'(ifb.in_addr)];
   end

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] exp_q [$];
   int          m_idx;
   int          done_seen;
   int          done_cyc;
   logic [63:0] first_word;
   logic [63:0] last_word;
   bit          sel;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: lay the low w bits of every coefficient into one long bitstream, cut into 64-bit words.
   task automatic build_exp(input int n, input int w);
      logic [256*13-1:0] s;
      int pos;
      s   = '0;
      pos = 0;
      for (int k = 0; k < n; k++) begin
         for (int b = 0; b < w; b++) begin
            s[pos] = coef[k][b];
            pos++;
         end
      end
      exp_q.delete();
      for (int j = 0; j < (n * w + 63) / 64; j++) begin
         exp_q.push_back(s[j*64 +: 64]);
      end
   endtask

   logic [63:0] m_out;
   logic        m_en;
   logic        m_done;
   int          m_addr;

   always_comb begin
      m_out  = sel ? ifb.out    : ifa.out;
      m_en   = sel ? ifb.out_en : ifa.out_en;
      m_done = sel ? ifb.done   : ifa.done;
      m_addr = sel ? int'(ifb.out_addr) : int'(ifa.out_addr);
   end

   always @(negedge clk) begin
      if (m_en) begin
         if (m_idx < exp_q.size()) begin
            check("word", m_out, exp_q[m_idx]);
            check("out_addr", 64'(m_addr), 64'(m_idx));
         end else begin
            check("extra_word", 64'(m_idx), 64'(exp_q.size()));
         end
         if (m_idx == 0) first_word = m_out;
         last_word = m_out;
         m_idx++;
      end
      if (m_done) begin
         done_seen++;
         done_cyc = cyc;
      end
   end

   task automatic check_idle(input string tag);
      check({tag, "_out"},      ifa.out,              64'd0);
      check({tag, "_out_en"},   64'(ifa.out_en),      64'd0);
      check({tag, "_out_addr"}, 64'(ifa.out_addr),    64'd0);
      check({tag, "_in_en"},    64'(ifa.in_en),       64'd0);
      check({tag, "_in_addr"},  64'(ifa.in_addr),     64'd0);
      check({tag, "_busy"},     64'(ifa.busy),        64'd0);
      check({tag, "_done"},     64'(ifa.done),        64'd0);
      check({tag, "_err"},      64'(ifa.err),         64'd0);
   endtask

   // Called just after a rising edge; start is high for exactly one cycle (t0).
   task automatic run_job(input bit s, input int n, input int w, input int flush, input int glitch_at);
      int t0;
      int k;
      build_exp(n, w);
      sel       = s;
      m_idx     = 0;
      done_seen = 0;
      done_cyc  = -1;
      #1;
      if (s) begin
         ifb.start = 1'b1;
         ifb.width = 4'(w);
      end else begin
         ifa.start = 1'b1;
         ifa.width = 4'(w);
      end
      t0 = cyc;
      @(posedge clk); #1;
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      k = 0;
      while (done_seen == 0 && k < n + 20) begin
         @(posedge clk); #1;
         k++;
         if (k == glitch_at) begin
            ifa.start = 1'b1;
            ifa.width = 4'd3;
         end else begin
            ifa.start = 1'b0;
         end
      end
      check("done_cycle",  64'(done_cyc - t0), 64'(n + 2 + flush));
      check("word_count",  64'(m_idx),         64'(exp_q.size()));
      check("done_pulses", 64'(done_seen),     64'd1);
   endtask

   task automatic err_test(input int w);
      #1;
      ifa.start = 1'b1;
      ifa.width = 4'(w);
      @(posedge clk); #1;
      ifa.start = 1'b0;
      @(negedge clk);
      check("err_pulse", 64'(ifa.err),   64'd1);
      check("err_busy",  64'(ifa.busy),  64'd0);
      check("err_in_en", 64'(ifa.in_en), 64'd0);
      @(posedge clk);
      @(negedge clk);
      check("err_clear", 64'(ifa.err),   64'd0);
      check("err_idle",  64'(ifa.busy),  64'd0);
      @(posedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0;
      rst       = 1'b1;
      ifa.start = 1'b0;
      ifa.width = '0;
      ifa.in    = '0;
      ifb.start = 1'b0;
      ifb.width = '0;
      ifb.in    = '0;
      sel       = 1'b0;
      m_idx     = 0;
      done_seen = 0;
      done_cyc  = -1;
      for (int k = 0; k < 256; k++) coef[k] = '0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Ramp data, widest field.
      for (int k = 0; k < 256; k++) coef[k] = 13'(k);
      run_job(1'b0, 256, 13, 0, 0);
      check("w13_word0_literal", first_word, 64'h0040_0180_0800_2000);

      // Saturated input at width 10, then only the masked-off upper bits set.
      for (int k = 0; k < 256; k++) coef[k] = 13'h1FFF;
      run_job(1'b0, 256, 10, 0, 0);
      check("w10_ones_first", first_word, 64'hFFFF_FFFF_FFFF_FFFF);
      check("w10_ones_last",  last_word,  64'hFFFF_FFFF_FFFF_FFFF);
      for (int k = 0; k < 256; k++) coef[k] = 13'h1C00;
      run_job(1'b0, 256, 10, 0, 0);
      check("w10_mask_first", first_word, 64'd0);
      check("w10_mask_last",  last_word,  64'd0);

      // 5 x 13 = 65 bits: one full word plus a one-bit flushed word.
      coef[0] = 13'h1ABC;
      coef[1] = 13'h0123;
      coef[2] = 13'h1FFF;
      coef[3] = 13'h0555;
      coef[4] = 13'h1AAB;
      run_job(1'b1, 5, 13, 1, 0);
      check("n5_word0_literal", first_word, 64'hAAB2_AAFF_FC24_7ABC);
      check("n5_flush_literal", last_word,  64'h0000_0000_0000_0001);

      sel = 1'b0;
      err_test(0);
      err_test(14);

      // Abort a width-4 job with reset at its cycle 20.
      for (int k = 0; k < 256; k++) coef[k] = 13'($urandom);
      build_exp(256, 4);
      m_idx     = 0;
      done_seen = 0;
      #1;
      ifa.start = 1'b1;
      ifa.width = 4'd4;
      t0 = cyc;
      @(posedge clk); #1;
      ifa.start = 1'b0;
      while (cyc < t0 + 20) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_idle("abort");
      repeat (300) @(posedge clk);
      check("abort_done",  64'(done_seen), 64'd0);
      check("abort_words", 64'(m_idx),     64'd1);

      run_job(1'b0, 256, 6, 0, 0);

      // Start pulsed mid-job (ignored), then a back-to-back job the cycle after done.
      for (int k = 0; k < 256; k++) coef[k] = 13'($urandom);
      run_job(1'b0, 256, 13, 0, 50);
      run_job(1'b0, 256, 4, 0, 0);
      run_job(1'b0, 256, 3, 0, 0);

      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
